// File: rtl/muldiv_unit_if.sv
// Write-back and request bundle for the KGPRISC multiply/divide unit.
//
// master (decoder / register bank side): drives req, op, a, b, dest;
//   receives busy, done, we, wr, data.
// slave (muldiv_unit side): the mirror image.
//
//   req   - operation request, honoured only while the unit is idle
//   op    - 00 MUL, 01 MULH, 10 DIVU, 11 REMU
//   a, b  - rd1 / rd2 operands (multiplicand/dividend, multiplier/divisor)
//   dest  - destination register number
//   busy  - unit is working; the decoder stalls while high
//   done  - one-cycle completion pulse, coincident with we
//   we/wr/data - register-bank write port
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       dest;
  logic             busy;
  logic             done;
  logic             we;
  logic [4:0]       wr;
  logic [WIDTH-1:0] data;

  modport master (
    output req, op, a, b, dest,
    input  busy, done, we, wr, data
  );

  modport slave (
    input  req, op, a, b, dest,
    output busy, done, we, wr, data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit for KGPRISC.
//
// Accepts one request while idle, runs 32 radix-2 iterations (shift-add
// multiply or restoring divide) and then presents a single-cycle write-back
// to the register bank. Divide by zero skips the iterations and writes back
// on the cycle after acceptance.
//
// Ports:
//   clk    - system clock, rising edge
//   start  - asynchronous active-low reset; aborts any operation in flight
//   bus    - muldiv_unit_if slave modport (request in, write-back out)
//
// All outputs are decoded from registered state only.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           start,
  muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [4:0]         dest_q, dest_d;
  // Multiplicand for MUL/MULH, divisor for DIVU/REMU.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Multiply: {high partial product, remaining multiplier bits}.
  // Divide:   low half holds dividend bits shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Divide partial remainder; always below the divisor between iterations,
  // so WIDTH bits are enough once the 33-bit trial compare is done.
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   result;

  // Datapath for one iteration, shared by the RUN state below.
  always_comb begin
    mul_add   = acc_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // The true difference is below 2^WIDTH whenever div_ge holds.
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dest_d  = dest_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          op_d   = bus.op;
          dest_d = bus.dest;
          cnt_d  = '0;
          rem_d  = '0;
          if (bus.op[1]) begin
            if (bus.b == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              opnd_d  = bus.b;
              acc_d   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              rem_d   = bus.a;
              state_d = ST_WB;
            end else begin
              opnd_d  = bus.b;
              acc_d   = {{WIDTH{1'b0}}, bus.a};
              state_d = ST_RUN;
            end
          end else begin
            opnd_d  = bus.a;
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (!op_q[1]) begin
          // Carry out of the upper-half add becomes the new bit 63.
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
          rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = ST_WB;
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge start) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of order.
    if (!start) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dest_q  <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    result = '0;
    unique case (op_q)
      OP_MUL:  result = acc_q[WIDTH-1:0];
      OP_MULH: result = acc_q[2*WIDTH-1:WIDTH];
      OP_DIVU: result = acc_q[WIDTH-1:0];
      OP_REMU: result = rem_q;
      default: result = '0;
    endcase
  end

  // Write-back fields are forced to zero outside WB so the register-bank
  // port sees a clean idle value.
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_WB);
  assign bus.we   = (state_q == ST_WB);
  assign bus.wr   = (state_q == ST_WB) ? dest_q : '0;
  assign bus.data = (state_q == ST_WB) ? result : '0;

endmodule
